// File: rtl/image_control_pkg.sv
// Shared definitions for the 3x3 window sequencer: FSM encoding and ring geometry.
package image_control_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

   localparam int NUM_LINES = 4;
   localparam int ROWS      = 3;

endpackage

// File: rtl/image_control_line_buffer.sv
// One line of pixel storage with a write pointer and a registered 3-pixel-wide read port.
module line_buffer #(
   parameter int IMG_WIDTH = 512
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [7:0]  i_data,
   input  logic        i_data_valid,
   input  logic        i_rd_data,
   output logic [23:0] o_data
);

   localparam int PTR_W = $clog2(IMG_WIDTH);

   logic [7:0]       mem [IMG_WIDTH];
   logic [PTR_W-1:0] wp_q, wp_d;
   logic [PTR_W-1:0] rp_q, rp_d;
   logic [23:0]      data_q, data_d;

   always_comb begin
      wp_d   = wp_q;
      rp_d   = rp_q;
      data_d = data_q;
      if (i_data_valid) begin
         wp_d = (wp_q == PTR_W'(IMG_WIDTH - 1)) ? '0 : wp_q + PTR_W'(1);
      end
      if (i_rd_data) begin
         data_d = {mem[rp_q + PTR_W'(2)], mem[rp_q + PTR_W'(1)], mem[rp_q]};
         rp_d   = (rp_q == PTR_W'(IMG_WIDTH - 3)) ? '0 : rp_q + PTR_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         wp_q   <= '0;
         rp_q   <= '0;
         data_q <= '0;
      end else begin
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         data_q <= data_d;
      end
   end

   // Storage is never cleared; writes are simply ignored while reset is held.
   always_ff @(posedge i_clk) begin
      if (i_rstn && i_data_valid) begin
         mem[wp_q] <= i_data;
      end
   end

   assign o_data = data_q;

endmodule

// File: rtl/image_control.sv
// Line-buffer ring sequencer: stores raster lines and bursts 3x3 windows once three lines are held.
module image_control
   import image_control_pkg::*;
#(
   parameter int IMG_WIDTH = 512,
   parameter int CNT_W     = 12
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [7:0]  i_pixel_data,
   input  logic        i_pixel_data_valid,
   input  logic        i_run,
   output logic [71:0] o_pixel_data,
   output logic        o_pixel_data_valid,
   output logic        o_intr,
   output logic        o_overflow
);

   localparam int COL_W  = $clog2(IMG_WIDTH);
   localparam int LINE_W = $clog2(NUM_LINES);

   localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(IMG_WIDTH);
   localparam logic [CNT_W-1:0] RUN_CNT  = CNT_W'(ROWS * IMG_WIDTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_LINES * IMG_WIDTH);

   state_t            state_q, state_d;
   logic [COL_W-1:0]  wr_col_q, wr_col_d;
   logic [COL_W-1:0]  rd_col_q, rd_col_d;
   logic [LINE_W-1:0] wr_line_q, wr_line_d;
   logic [LINE_W-1:0] rd_line_q, rd_line_d;
   logic [LINE_W-1:0] sel_line_q, sel_line_d;
   logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic              valid_q, valid_d;
   logic              intr_q, intr_d;
   logic              overflow_q, overflow_d;

   logic                 rd_issue;
   logic                 line_release;
   logic [NUM_LINES-1:0] lb_wr;
   logic [NUM_LINES-1:0] lb_rd;
   logic [23:0]          lb_data [NUM_LINES];

   always_comb begin
      wr_col_d  = wr_col_q;
      wr_line_d = wr_line_q;
      if (i_pixel_data_valid) begin
         if (wr_col_q == COL_W'(IMG_WIDTH - 1)) begin
            wr_col_d  = '0;
            wr_line_d = wr_line_q + LINE_W'(1);
         end else begin
            wr_col_d = wr_col_q + COL_W'(1);
         end
      end
   end

   // Entry decision uses the registered count, so a fresh line is never read in its write cycle.
   always_comb begin
      state_d      = state_q;
      rd_col_d     = rd_col_q;
      rd_line_d    = rd_line_q;
      rd_issue     = 1'b0;
      line_release = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_run && (pix_cnt_q >= RUN_CNT)) begin
               state_d = READ;
            end
         end
         READ: begin
            rd_issue = 1'b1;
            if (rd_col_q == COL_W'(IMG_WIDTH - 3)) begin
               line_release = 1'b1;
               state_d      = IDLE;
               rd_col_d     = '0;
               rd_line_d    = rd_line_q + LINE_W'(1);
            end else begin
               rd_col_d = rd_col_q + COL_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pix_cnt_d = pix_cnt_q + CNT_W'(i_pixel_data_valid) - (line_release ? LINE_CNT : '0);
      overflow_d = overflow_q |
                   (i_pixel_data_valid && (pix_cnt_q == FULL_CNT) && !line_release);
      valid_d    = rd_issue;
      intr_d     = line_release;
      sel_line_d = rd_issue ? rd_line_q : sel_line_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q    <= IDLE;
         wr_col_q   <= '0;
         wr_line_q  <= '0;
         rd_col_q   <= '0;
         rd_line_q  <= '0;
         sel_line_q <= '0;
         pix_cnt_q  <= '0;
         valid_q    <= 1'b0;
         intr_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_col_q   <= wr_col_d;
         wr_line_q  <= wr_line_d;
         rd_col_q   <= rd_col_d;
         rd_line_q  <= rd_line_d;
         sel_line_q <= sel_line_d;
         pix_cnt_q  <= pix_cnt_d;
         valid_q    <= valid_d;
         intr_q     <= intr_d;
         overflow_q <= overflow_d;
      end
   end

   // Only the three lines of the current window advance their read pointers.
   always_comb begin
      lb_wr = '0;
      lb_rd = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         lb_wr[i] = i_pixel_data_valid && (wr_line_q == LINE_W'(i));
         lb_rd[i] = rd_issue && ((LINE_W'(i) - rd_line_q) < LINE_W'(ROWS));
      end
   end

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_lb
      line_buffer #(
         .IMG_WIDTH (IMG_WIDTH)
      ) u_lb (
         .i_clk        (i_clk),
         .i_rstn       (i_rstn),
         .i_data       (i_pixel_data),
         .i_data_valid (lb_wr[g]),
         .i_rd_data    (lb_rd[g]),
         .o_data       (lb_data[g])
      );
   end

   // Muxed by the line index latched at issue time, so the window survives rd_line advancing.
   assign o_pixel_data = {lb_data[sel_line_q + LINE_W'(2)],
                          lb_data[sel_line_q + LINE_W'(1)],
                          lb_data[sel_line_q]};

   assign o_pixel_data_valid = valid_q;
   assign o_intr             = intr_q;
   assign o_overflow         = overflow_q;

endmodule

// File: tb/tb_image_control.sv
// Scoreboard bench for image_control: a line-ring model queues expected windows, a monitor compares them.
module tb_image_control;

   localparam int W = 8;

   logic        i_clk;
   logic        i_rstn;
   logic [7:0]  i_pixel_data;
   logic        i_pixel_data_valid;
   logic        i_run;
   logic [71:0] o_pixel_data;
   logic        o_pixel_data_valid;
   logic        o_intr;
   logic        o_overflow;

   image_control #(
      .IMG_WIDTH (W),
      .CNT_W     (12)
   ) dut (
      .i_clk              (i_clk),
      .i_rstn             (i_rstn),
      .i_pixel_data       (i_pixel_data),
      .i_pixel_data_valid (i_pixel_data_valid),
      .i_run              (i_run),
      .o_pixel_data       (o_pixel_data),
      .o_pixel_data_valid (o_pixel_data_valid),
      .o_intr             (o_intr),
      .o_overflow         (o_overflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int tests_run = 0;
   int fail_cnt  = 0;

   logic [7:0]  mdl_mem [4][W];
   int          m_col, m_line, m_lines_done, m_phases, stream_idx;
   bit          m_run;
   logic [71:0] exp_q [$];

   int          cyc = 0;
   int          win_cnt, intr_cnt, intr_cyc;
   int          stamps [$];
   logic [71:0] first_win, last_win;

   task automatic checkOutput(string name, logic [71:0] act, logic [71:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] window(int base, int c);
      logic [71:0] w = '0;
      for (int r = 0; r < 3; r++)
         for (int b = 0; b < 3; b++)
            w[r*24 + b*8 +: 8] = mdl_mem[(base + r) % 4][c + b];
      return w;
   endfunction

   // Every three unconsumed complete lines yield one burst of W-2 windows, oldest line on top.
   task automatic modelPhases();
      while (m_run && (m_lines_done - m_phases >= 3)) begin
         for (int c = 0; c <= W - 3; c++) exp_q.push_back(window(m_phases % 4, c));
         m_phases++;
      end
   endtask

   task automatic modelWrite(logic [7:0] v);
      mdl_mem[m_line][m_col] = v;
      if (m_col == W - 1) begin
         m_col = 0;
         m_line = (m_line + 1) % 4;
         m_lines_done++;
      end else begin
         m_col++;
      end
      modelPhases();
   endtask

   task automatic modelReset();
      m_col = 0; m_line = 0; m_lines_done = 0; m_phases = 0; stream_idx = 0;
      exp_q.delete();
   endtask

   task automatic clearStats();
      win_cnt = 0; intr_cnt = 0; intr_cyc = -1;
      stamps.delete();
      first_win = '0; last_win = '0;
   endtask

   task automatic applyStimulus(bit v, logic [7:0] d);
      @(negedge i_clk);
      i_pixel_data_valid = v;
      i_pixel_data = d;
      if (v) modelWrite(d);
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00);
   endtask

   task automatic sendPattern(int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b1, 8'((stream_idx / W) * 16 + (stream_idx % W)));
         stream_idx++;
      end
   endtask

   task automatic sendRandom(int n);
      for (int k = 0; k < n; k++) begin
         idle($urandom_range(0, 2));
         applyStimulus(1'b1, 8'($urandom));
      end
   endtask

   task automatic setRun(bit r);
      i_run = r;
      m_run = r;
      modelPhases();
   endtask

   task automatic doReset(int n, bit with_pixels);
      i_rstn = 1'b0;
      i_pixel_data_valid = with_pixels;
      i_pixel_data = 8'($urandom);
      modelReset();
      for (int k = 0; k < n; k++) begin
         @(negedge i_clk);
         i_pixel_data = 8'($urandom);
      end
      checkOutput("reset_data", o_pixel_data, '0);
      checkOutput("reset_valid", 72'(o_pixel_data_valid), 0);
      checkOutput("reset_intr", 72'(o_intr), 0);
      checkOutput("reset_overflow", 72'(o_overflow), 0);
      i_rstn = 1'b1;
      i_pixel_data_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
      idle(4);
      checkOutput("drain_empty", 72'(exp_q.size()), 0);
   endtask

   // Monitor: samples just after each rising edge and pops the scoreboard on every valid window.
   always @(posedge i_clk) begin
      #1;
      cyc++;
      if (o_pixel_data_valid === 1'b1) begin
         win_cnt++;
         stamps.push_back(cyc);
         if (win_cnt == 1) first_win = o_pixel_data;
         last_win = o_pixel_data;
         if (exp_q.size() == 0) begin
            tests_run++;
            fail_cnt++;
            $display("[TB] FAIL unexpected_window: got %0h, expected no window", o_pixel_data);
         end else begin
            checkOutput("window", o_pixel_data, exp_q.pop_front());
         end
      end
      if (o_intr === 1'b1) begin
         intr_cnt++;
         intr_cyc = cyc;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      i_run = 1'b1;
      m_run = 1'b1;
      i_pixel_data = '0;
      i_pixel_data_valid = 1'b0;
      clearStats();

      // Reset held with live pixels, then 23 pixels must not be enough.
      doReset(3, 1'b1);
      clearStats();
      sendPattern(23);
      idle(10);
      checkOutput("partial_no_valid", 72'(win_cnt), 0);
      checkOutput("partial_no_intr", 72'(intr_cnt), 0);

      sendPattern(1);
      drain();
      checkOutput("first_phase_windows", 72'(win_cnt), 6);
      checkOutput("valid_consecutive",
                  72'((stamps.size() == 6) ? stamps[5] - stamps[0] : -1), 5);
      checkOutput("first_window", first_win, 72'h22_21_20_12_11_10_02_01_00);
      checkOutput("last_window", last_win, 72'h27_26_25_17_16_15_07_06_05);
      checkOutput("intr_count_1", 72'(intr_cnt), 1);
      checkOutput("intr_timing", 72'(intr_cyc), 72'((stamps.size() == 6) ? stamps[5] : -1));

      $display("[TB] six lines streamed continuously");
      doReset(1, 1'b0);
      clearStats();
      sendPattern(6 * W);
      drain();
      checkOutput("stream_windows", 72'(win_cnt), 24);
      checkOutput("stream_intr", 72'(intr_cnt), 4);
      checkOutput("wrap_last_window", last_win, 72'h57_56_55_47_46_45_37_36_35);
      checkOutput("stream_overflow", 72'(o_overflow), 0);

      $display("[TB] overflow with run held low");
      doReset(1, 1'b0);
      setRun(1'b0);
      clearStats();
      sendPattern(4 * W);
      idle(1);
      checkOutput("overflow_before", 72'(o_overflow), 0);
      sendPattern(1);
      idle(1);
      checkOutput("overflow_set", 72'(o_overflow), 1);
      idle(5);
      checkOutput("run_low_no_valid", 72'(win_cnt), 0);
      setRun(1'b1);
      drain();
      checkOutput("overflow_windows", 72'(win_cnt), 12);
      checkOutput("overflow_intr", 72'(intr_cnt), 2);
      checkOutput("overflow_sticky", 72'(o_overflow), 1);

      $display("[TB] random data with random gaps");
      doReset(1, 1'b0);
      clearStats();
      sendRandom(6 * W);
      drain();
      checkOutput("random_windows", 72'(win_cnt), 24);
      checkOutput("random_intr", 72'(intr_cnt), 4);

      $display("[TB] reset in the middle of a read phase");
      doReset(1, 1'b0);
      clearStats();
      sendPattern(3 * W);
      for (int i = 0; i < 60 && win_cnt < 3; i++) idle(1);
      checkOutput("mid_reset_reached", 72'(win_cnt >= 3), 1);
      doReset(1, 1'b0);
      clearStats();
      idle(10);
      checkOutput("aborted_no_windows", 72'(win_cnt), 0);
      checkOutput("aborted_no_intr", 72'(intr_cnt), 0);
      sendPattern(3 * W);
      drain();
      checkOutput("restart_windows", 72'(win_cnt), 6);
      checkOutput("restart_first_window", first_win, 72'h22_21_20_12_11_10_02_01_00);
      checkOutput("restart_intr", 72'(intr_cnt), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule

// File: doc/image_control.md
Name: image_control

Overview:
- Sequencing front end for the 3x3 convolution datapath.
- Accepts a raster pixel stream (one 8-bit pixel per valid cycle) and stores it in a ring of four line buffers.
- Once three full lines are stored, it issues a burst of 72-bit 3x3 windows to the convolver and frees the oldest line.
- Pulses o_intr after each freed line so the upstream DMA can send one more line.

Parameters:
- IMG_WIDTH, 512, pixels per line (>=4).
- CNT_W, 12, width of the stored-pixel counter; must hold 4*IMG_WIDTH.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rstn  input  1  synchronous, active-low reset.
- i_pixel_data  input  8  incoming pixel, raster order.
- i_pixel_data_valid  input  1  pixel qualifier; no backpressure.
- i_run  input  1  1 = read phases may start; 0 = hold off new read phases.
- o_pixel_data  output  72  3x3 window to the convolver.
- o_pixel_data_valid  output  1  window qualifier.
- o_intr  output  1  one-cycle pulse per freed line.
- o_overflow  output  1  sticky; set when a pixel is written into a full ring.

Behaviour:
- Reset (i_rstn=0 at a clock edge) forces the following; line-buffer contents are not cleared:
  - All outputs: o_pixel_data=0, o_pixel_data_valid=0, o_intr=0, o_overflow=0.
  - wr_col=0, wr_line=0, rd_col=0, rd_line=0, pix_cnt=0, state=IDLE.
- Reset mid-operation aborts any read phase immediately; valid is low from the next cycle.
- Write side:
  - On each valid pixel, write to line buffer wr_line at column wr_col, then wr_col++.
  - At wr_col==IMG_WIDTH-1: wr_col wraps to 0 and wr_line advances mod 4 (3->0).
- pix_cnt: +1 per accepted write; -IMG_WIDTH on line release.
- Write and release in the same cycle: pix_cnt = pix_cnt + 1 - IMG_WIDTH.
- Overflow: a write while pix_cnt==4*IMG_WIDTH with no release that cycle sets o_overflow. The write still lands and corrupts the oldest line. o_overflow clears only on reset.
- FSM states: IDLE and READ.
  - IDLE -> READ when i_run=1 and pix_cnt>=3*IMG_WIDTH. This uses the registered count, so there is at least one cycle between the last needed write and the first read.
  - READ issues one read per cycle for rd_col = 0 .. IMG_WIDTH-3 (IMG_WIDTH-2 windows); no stalls.
  - On the cycle issuing rd_col==IMG_WIDTH-3: state -> IDLE, rd_col -> 0, rd_line advances mod 4, and the line is released.
  - o_intr is high the following cycle.
  - Back-to-back phases are allowed: IDLE may re-enter READ on the next cycle.
  - i_run deasserted during READ does not abort the current phase.
- Read latency: line buffers have a registered read. o_pixel_data and o_pixel_data_valid appear one cycle after a read is issued.
- Window layout:
  - Rows: top = line rd_line (oldest), mid = rd_line+1, bottom = rd_line+2 (mod 4).
  - o_pixel_data[23:0] = top, [47:24] = mid, [71:48] = bottom.
  - Within each 24-bit row: byte0 = column rd_col, byte1 = rd_col+1, byte2 = rd_col+2.
- When not valid, o_pixel_data holds its last value.

Decomposition:
- Shared package: state encoding (IDLE, READ), NUM_LINES=4, ROWS=3.
- One sub-module, line_buffer (parameter IMG_WIDTH):
  - Ports: i_clk, i_rstn, i_data[7:0], i_data_valid, i_rd_data, o_data[23:0].
  - Internal write/read pointers.
  - Registered 3-pixel read {mem[rp+2], mem[rp+1], mem[rp]}; rp resets to 0 at end of line.
- Four instances. image_control demuxes writes by wr_line and muxes outputs by rd_line.

Test Plan:
- Bench runs IMG_WIDTH=8, i_run=1 unless stated. Pixel value = row*16+col.
- Reset: hold i_rstn=0 for 3 cycles with valid pixels driven -> all outputs 0, no writes counted; 24 further pixels are still needed before the first valid.
- 23 pixels only -> o_pixel_data_valid never rises; o_intr stays 0.
- 24 pixels back-to-back:
  - Exactly 6 consecutive valid windows.
  - First window = 72'h22_21_20_12_11_10_02_01_00; last = 72'h27_26_25_17_16_15_07_06_05.
  - One o_intr pulse the cycle after the last read is issued.
- Stream 6 lines continuously:
  - Four read phases in total.
  - The fourth phase uses rows 3, 0(=line 4 data), 1 and shows rd_line wrap.
  - pix_cnt stays consistent when a write and a release land in the same cycle; 4 o_intr pulses in total.
- i_run=0, write 33 pixels -> o_overflow=1 on the 33rd write and stays set. Then raise i_run -> a read phase proceeds normally.
- Assert i_rstn=0 during the 3rd window of a READ phase:
  - Valid is low the next cycle.
  - A fresh 24 pixels then produce windows starting again from line 0 data.
